axi4_slave_write_resp_channel: RTL and testbench

Write-response (B) stage of the AXI4 slave, directly downstream of the write data channel. It queues accepted write-address IDs and detects completed data bursts, using the data channel's `count_done` and `wlast`. For each completed burst it presents one B-channel response (`bid`, `bresp`) to the master with a valid/ready handshake. Back-pressure flags let the address and data stages stall when queues fill.

---
 rtl/axi4_slave_write_resp_channel.sv | 108 ++++++++++
 tb/tb_axi4_slave_write_resp_channel.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_write_resp_channel.sv
// axi4_slave_write_resp_channel: queues AW IDs, turns completed W bursts into B responses
// and presents them through a registered valid/ready output stage.
module axi4_slave_write_resp_channel #(
   parameter int ID_WIDTH    = 4,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                awvalid,
   input  logic                awready,
   input  logic [ID_WIDTH-1:0] awid,
   input  logic                wvalid,
   input  logic                wready,
   input  logic                wlast,
   input  logic [ID_WIDTH-1:0] wid,
   input  logic                count_done,
   input  logic                bready,
   output logic                bvalid,
   output logic [ID_WIDTH-1:0] bid,
   output logic [1:0]          bresp,
   output logic                aw_queue_full,
   output logic                b_queue_full,
   output logic                overflow
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam logic [PW:0] DEPTH = (PW+1)'(QUEUE_DEPTH);
   localparam logic [PW:0] C1 = (PW+1)'(1);
   localparam logic [PW-1:0] P1 = PW'(1);
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   typedef enum logic {B_IDLE, B_VALID} b_state_t;
   logic [ID_WIDTH-1:0] aw_mem [QUEUE_DEPTH];
   logic [ID_WIDTH+1:0] b_mem [QUEUE_DEPTH];
   logic [PW-1:0] aw_wp, aw_rp, b_wp, b_rp;
   logic [PW:0] aw_cnt, b_cnt;
   b_state_t state, state_nx;
   logic burst, aw_has, aw_pop, aw_push, aw_drop, b_pop, b_push, b_drop, load;
   logic [ID_WIDTH-1:0] head, rsp_id;
   logic [1:0] rsp_code;
   logic [ID_WIDTH+1:0] load_val;
   always_comb begin
      burst    = wvalid && wready && wlast;
      aw_has   = aw_cnt != '0;
      head     = aw_mem[aw_rp];
      aw_pop   = burst && aw_has;
      aw_push  = awvalid && awready && (aw_cnt != DEPTH || aw_pop);
      aw_drop  = awvalid && awready && !aw_push;
      rsp_id   = aw_has ? head : wid;
      rsp_code = (aw_has && count_done && wid == head) ? OKAY : SLVERR;
      b_pop    = state == B_VALID && bready;
      b_push   = burst && (b_cnt != DEPTH || b_pop);
      b_drop   = burst && !b_push;
   end
   // The presented response stays in the queue until its handshake, so the
   // next one to present after a handshake sits one slot behind the head.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      load_val = b_mem[b_rp];
      if (state == B_IDLE) begin
         if (b_cnt != '0) begin
            state_nx = B_VALID;
            load     = 1'b1;
         end
      end else if (bready) begin
         if (b_cnt > C1) begin
            load     = 1'b1;
            load_val = b_mem[b_rp + P1];
         end else
            state_nx = B_IDLE;
      end
   end
   always_ff @(posedge clk)
      if (rst) state <= B_IDLE;
      else     state <= state_nx;
   always_ff @(posedge clk) begin
      if (aw_push) aw_mem[aw_wp] <= awid;
      if (b_push)  b_mem[b_wp] <= {rsp_id, rsp_code};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_wp    <= '0;
         aw_rp    <= '0;
         aw_cnt   <= '0;
         b_wp     <= '0;
         b_rp     <= '0;
         b_cnt    <= '0;
         bid      <= '0;
         bresp    <= OKAY;
         overflow <= 1'b0;
      end else begin
         if (aw_push) aw_wp <= aw_wp + P1;
         if (aw_pop)  aw_rp <= aw_rp + P1;
         aw_cnt <= aw_cnt + (aw_push ? C1 : '0) - (aw_pop ? C1 : '0);
         if (b_push) b_wp <= b_wp + P1;
         if (b_pop)  b_rp <= b_rp + P1;
         b_cnt <= b_cnt + (b_push ? C1 : '0) - (b_pop ? C1 : '0);
         if (load) begin
            bid   <= load_val[ID_WIDTH+1:2];
            bresp <= load_val[1:0];
         end
         overflow <= overflow | aw_drop | b_drop;
      end
   end
   assign bvalid        = state == B_VALID;
   assign aw_queue_full = aw_cnt == DEPTH;
   assign b_queue_full  = b_cnt == DEPTH;
endmodule

// File: tb/tb_axi4_slave_write_resp_channel.sv
// tb_axi4_slave_write_resp_channel: directed vectors for the B-response stage.
module tb_axi4_slave_write_resp_channel;
   localparam int IW = 4;
   logic clk = 1'b0;
   logic rst, awvalid, awready, wvalid, wready, wlast, count_done, bready;
   logic bvalid, aw_queue_full, b_queue_full, overflow;
   logic [IW-1:0] awid, wid, bid;
   logic [1:0] bresp;
   int n_cmp = 0;
   int n_bad = 0;
   logic [IW+1:0] got [$];

   always #5 clk = ~clk;

   axi4_slave_write_resp_channel #(.ID_WIDTH(IW), .QUEUE_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .awvalid(awvalid), .awready(awready), .awid(awid),
      .wvalid(wvalid), .wready(wready), .wlast(wlast), .wid(wid),
      .count_done(count_done), .bready(bready), .bvalid(bvalid), .bid(bid),
      .bresp(bresp), .aw_queue_full(aw_queue_full), .b_queue_full(b_queue_full),
      .overflow(overflow)
   );

   // records every handshake that the next rising edge will complete
   always @(negedge clk) if (!rst && bvalid && bready) got.push_back({bid, bresp});

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_aw(input logic [IW-1:0] id);
      awvalid = 1'b1;
      awready = 1'b1;
      awid    = id;
      step();
      awvalid = 1'b0;
      awready = 1'b0;
   endtask

   task automatic do_burst(input logic [IW-1:0] id, input logic cd, input int beats);
      for (int i = 1; i <= beats; i++) begin
         wvalid     = 1'b1;
         wready     = 1'b1;
         wlast      = (i == beats);
         count_done = (i == beats) && cd;
         wid        = id;
         step();
      end
      wvalid     = 1'b0;
      wready     = 1'b0;
      wlast      = 1'b0;
      count_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; awvalid = 1'b0; awready = 1'b0; awid = '0; wvalid = 1'b0;
      wready = 1'b0; wlast = 1'b0; wid = '0; count_done = 1'b0; bready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_bvalid", bvalid, 0);
      check("rst_bid", bid, 0);
      check("rst_bresp", bresp, 0);
      check("rst_aw_full", aw_queue_full, 0);
      check("rst_b_full", b_queue_full, 0);
      check("rst_overflow", overflow, 0);

      bready = 1'b1;
      do_aw(3);
      do_burst(3, 1'b1, 4);
      check("single_latency", bvalid, 0);
      step();
      check("single_bvalid", bvalid, 1);
      check("single_bid", bid, 3);
      check("single_bresp", bresp, 2'b00);
      step();
      check("single_drop", bvalid, 0);

      do_aw(5);
      do_burst(6, 1'b1, 2);
      step();
      check("mismatch_bid", bid, 5);
      check("mismatch_bresp", bresp, 2'b10);
      step();
      check("mismatch_drop", bvalid, 0);

      do_aw(9);
      do_burst(9, 1'b0, 3);
      step();
      check("early_bid", bid, 9);
      check("early_bresp", bresp, 2'b10);
      step();

      do_burst(4'hA, 1'b1, 1);
      step();
      check("noaw_bid", bid, 4'hA);
      check("noaw_bresp", bresp, 2'b10);
      step();
      check("noaw_drop", bvalid, 0);

      bready = 1'b0;
      for (int i = 1; i <= 4; i++) do_aw(IW'(i));
      check("stall_aw_full", aw_queue_full, 1);
      for (int i = 1; i <= 4; i++) do_burst(IW'(i), 1'b1, 1);
      check("stall_b_full", b_queue_full, 1);
      check("stall_aw_empty", aw_queue_full, 0);
      check("stall_bvalid", bvalid, 1);
      check("stall_bid", bid, 1);
      step();
      step();
      check("stall_hold_bid", bid, 1);
      check("stall_hold_bvalid", bvalid, 1);
      bready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_bvalid", bvalid, 1);
         check("drain_bid", bid, i);
         step();
      end
      check("drain_done", bvalid, 0);
      check("drain_b_full", b_queue_full, 0);

      got.delete();
      for (int i = 1; i <= 4; i++) do_aw(IW'(i));
      check("ovf_pre_full", aw_queue_full, 1);
      check("ovf_pre", overflow, 0);
      do_aw(5);
      check("ovf_set", overflow, 1);
      for (int i = 1; i <= 4; i++) do_burst(IW'(i), 1'b1, 1);
      repeat (8) step();
      check("ovf_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         check("ovf_entry", (i < got.size()) ? got[i] : '1, {IW'(i + 1), 2'b00});
      check("ovf_sticky", overflow, 1);

      bready = 1'b0;
      do_aw(2);
      do_burst(2, 1'b1, 1);
      do_aw(3);
      step();
      check("mid_pre_bvalid", bvalid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_bvalid", bvalid, 0);
      check("mid_aw_full", aw_queue_full, 0);
      check("mid_b_full", b_queue_full, 0);
      check("mid_overflow", overflow, 0);
      got.delete();
      bready = 1'b1;
      do_aw(7);
      do_burst(7, 1'b1, 1);
      repeat (5) step();
      check("post_rst_count", got.size(), 1);
      check("post_rst_entry", (got.size() > 0) ? got[0] : '1, {IW'(7), 2'b00});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
